icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Serves pcF lookups combinationally on a hit.
- On a miss, asserts a stall into the hazard path and refills one line from a word-serial backing memory.
- Supports whole-cache invalidation (fence.i / self-modifying test programs).

Parameters:
- DATA_WIDTH, 32, instruction/word width
- ADDR_WIDTH, 32, byte address width
- NUM_LINES, 16, number of cache lines (power of 2)
- WORDS_PER_LINE, 4, words per line (power of 2, at least 2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_i  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- fetch_en_i  in  1  lookup request (tied to !stallF upstream)
- instr_o  out  DATA_WIDTH  instruction word; meaningful only when stall_o=0
- stall_o  out  1  miss/refill in progress; fetch must hold pc_i
- invalidate_i  in  1  clear all valid bits
- mem_req_valid_o  out  1  line-refill request
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  ADDR_WIDTH  line-aligned refill byte address
- mem_rvalid_i  in  1  refill data beat valid
- mem_rdata_i  in  DATA_WIDTH  refill data, beats in ascending word order

Behaviour:
- Address split:
  - byte offset [1:0]
  - word select: next log2(WORDS_PER_LINE) bits
  - index: next log2(NUM_LINES) bits
  - tag: remaining upper bits
  - Defaults: word [3:2], index [7:4], tag [31:8].
- Storage: per line, valid bit, tag, and WORDS_PER_LINE data words, all in flops. Only the valid bits are reset.
- Hit = fetch_en_i & valid[index] & (tag[index]==pc tag) & state==IDLE. On a hit, instr_o = selected word in the same cycle, with zero added latency.
- stall_o = (fetch_en_i & ~hit) | (state != IDLE). It is combinational and never depends on mem_* inputs in the same cycle.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE: on fetch_en_i & miss, latch line-aligned pc_i into refill_addr, go to REQ.
  - REQ: mem_req_valid_o=1, mem_addr_o=refill_addr, both held stable until mem_req_ready_i. Go to FILL on the accept edge; beat counter is 0.
  - FILL: each mem_rvalid_i writes mem_rdata_i into word[beat] of the target line and increments beat. On the last beat (beat==WORDS_PER_LINE-1), go to DONE. Gaps between beats are legal. mem_rvalid_i is ignored outside FILL.
  - DONE (1 cycle): write tag, set valid (unless dropped), go to IDLE. The lookup re-evaluates the following cycle and hits.
- Miss latency with ready in the REQ cycle and back-to-back beats: stall_o high for 2+WORDS_PER_LINE+1 cycles (7 at default), then the hit cycle.
- Valid is cleared for the target line on entry to REQ, so a partial line is never hit.
- pc_i changes during a refill (branch redirect): the refill completes unchanged, then the new pc_i is looked up in IDLE.
- invalidate_i:
  - In IDLE, REQ or FILL, all valid bits clear on the next edge.
  - If asserted in REQ/FILL/DONE, a drop flag is set; DONE then does not set valid. The flag clears in IDLE.
  - The refill itself is never aborted.
  - If invalidate_i and a miss occur together in IDLE, the invalidate applies and the refill also proceeds.
- Reset (including mid-refill):
  - state=IDLE, all valid=0, beat=0, drop=0.
  - Outputs: mem_req_valid_o=0, mem_addr_o=0, instr_o=0 (instr_o is gated to 0 while the line is invalid or stalled).
  - The backing memory is reset by the same rst, so no stale beats are expected.
- The beat counter is log2(WORDS_PER_LINE) bits and wraps to 0 on the last beat.

Decomposition:
- Shared pipeline package:
  - icache FSM state enum (IDLE, REQ, FILL, DONE)
  - localparams for OFFSET_BITS, WORD_BITS, INDEX_BITS, TAG_BITS, derived from the parameters
  - a function extracting index/tag/word from an address
- One natural sub-module, icache_refill_fsm: FSM, beat counter, drop flag and memory handshake. It emits write-enable, line index, word select and set_valid to the storage array kept in icache_dm.

Test Plan:
1. Cold miss: pc_i=0x00, memory ready immediately, beats 0xA0..0xA3 back-to-back.
   - mem_addr_o=0x00, stall_o high 7 cycles, then instr_o=0xA0 with stall_o=0.
   - pc 0x04/0x08/0x0C return 0xA1/0xA2/0xA3 with no mem_req_valid_o.
2. Conflict eviction: after test 1, pc_i=0x100 (same index 0, tag 1), beats 0xB0..0xB3.
   - Refill at 0x100, then instr_o=0xB0.
   - Return to pc_i=0x00 causes a miss again.
3. Handshake stalls: mem_req_ready_i held low 3 cycles, one idle cycle between each beat.
   - mem_req_valid_o and mem_addr_o stay stable while waiting.
   - Data lands in correct word order; stall_o lasts exactly until DONE+1.
4. Invalidate:
   - Fill lines 0 and 1, pulse invalidate_i in IDLE: both pcs then miss.
   - Pulse invalidate_i during FILL: the line completes but the next lookup of that pc misses again.
5. Redirect mid-refill: pc_i changes 0x20 to 0x40 during FILL.
   - Line 0x20 completes and is valid.
   - A second refill for 0x40 follows; a later lookup of 0x20 hits.
6. Reset mid-FILL after 2 beats: assert rst asynchronously.
   - mem_req_valid_o=0 and stall_o=0 (fetch_en_i low) immediately.
   - After release, pc_i=0x00 misses and a full refill occurs.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the refill FSM state enum, the default cache geometry with its
// derived address-field widths, and a helper that extracts a bit field
// (word select, index or tag) from a byte address.
package icache_dm_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_NUM_LINES      = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Address split for the default geometry: tag | index | word | byte.
  localparam int OFFSET_BITS = 2;
  localparam int WORD_BITS   = $clog2(DEF_WORDS_PER_LINE);
  localparam int INDEX_BITS  = $clog2(DEF_NUM_LINES);
  localparam int TAG_BITS    = DEF_ADDR_WIDTH - INDEX_BITS - WORD_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } icache_state_e;

  // Returns addr[lsb +: width], zero-extended. Callers size-cast the
  // result to the field width of their own geometry.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int lsb,
                                             input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line-refill controller for icache_dm.
// Sequences IDLE -> REQ -> FILL -> DONE, runs the request handshake to the
// word-serial backing memory, counts refill beats and remembers whether an
// invalidate arrived while the refill was in flight (drop flag).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           miss detected in IDLE; latch line_addr and request
//   line_addr       line-aligned byte address of the missing line
//   invalidate      whole-cache invalidate request
//   mem_req_ready   memory accepts the refill request
//   mem_rvalid      refill data beat valid
//   state           current FSM state (also useful for debug)
//   mem_req_valid   registered refill request
//   mem_addr        registered line address of the current/last refill
//   wr_en           write mem_rdata into word wr_word of the target line
//   wr_word         word select of the beat being written
//   fill_done       DONE cycle: the target line's tag is written
//   set_valid       DONE cycle and the refill was not dropped
//
// Handshake: a request transfers on a rising edge where mem_req_valid and
// mem_req_ready are both high; mem_req_valid and mem_addr hold steady until
// then. Each cycle with mem_rvalid high in FILL transfers one data beat.
module icache_refill_fsm
  import icache_dm_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             line_addr,
  input  logic                              invalidate,
  input  logic                              mem_req_ready,
  input  logic                              mem_rvalid,
  output icache_state_e                     state,
  output logic                              mem_req_valid,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              wr_en,
  output logic [$clog2(WORDS_PER_LINE)-1:0] wr_word,
  output logic                              fill_done,
  output logic                              set_valid
);

  localparam int BEAT_BITS = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_LINE - 1);

  icache_state_e         state_q;
  logic [BEAT_BITS-1:0]  beat_q;
  logic                  drop_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] refill_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      drop_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      refill_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drop_q <= 1'b0;
          if (start) begin
            refill_addr_q <= line_addr;
            req_valid_q   <= 1'b1;
            state_q       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (invalidate) drop_q <= 1'b1;
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            beat_q      <= '0;
            state_q     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (invalidate) drop_q <= 1'b1;
          if (mem_rvalid) begin
            // Counter wraps to 0 on the last beat by construction.
            beat_q <= beat_q + BEAT_BITS'(1);
            if (beat_q == LAST_BEAT) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (invalidate) drop_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state         = state_q;
  assign mem_req_valid = req_valid_q;
  assign mem_addr      = refill_addr_q;
  assign wr_en         = (state_q == ST_FILL) & mem_rvalid;
  assign wr_word       = beat_q;
  assign fill_done     = (state_q == ST_DONE);
  // An invalidate landing in the DONE cycle itself also suppresses valid.
  assign set_valid     = (state_q == ST_DONE) & ~drop_q & ~invalidate;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache in front of the fetch stage.
// Hits return the selected word combinationally; a miss raises stall and
// refills the whole line from a word-serial backing memory, after which the
// lookup re-evaluates and hits. invalidate clears every valid bit.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   pc_i             fetch byte address (bits [1:0] ignored)
//   fetch_en_i       lookup request
//   instr_o          instruction word; 0 unless hitting
//   stall_o          miss or refill in progress; fetch holds pc_i
//   invalidate_i     clear all valid bits
//   mem_req_valid_o  refill request, held until mem_req_ready_i
//   mem_req_ready_i  memory accepts request
//   mem_addr_o       line-aligned refill byte address
//   mem_rvalid_i     refill beat valid
//   mem_rdata_i      refill data, ascending word order
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  fetch_en_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  stall_o,
  input  logic                  invalidate_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int WSEL_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int WSEL_LSB  = OFFSET_BITS;
  localparam int IDX_LSB   = WSEL_LSB + WSEL_BITS;
  localparam int TG_LSB    = IDX_LSB + IDX_BITS;
  localparam int TG_BITS   = ADDR_WIDTH - TG_LSB;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((64'd1 << IDX_LSB) - 64'd1);

  // Storage: only the valid bits are reset; tag and data are qualified by valid.
  logic [NUM_LINES-1:0]  valid_q;
  logic [TG_BITS-1:0]    tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

  logic [WSEL_BITS-1:0]  pc_word;
  logic [IDX_BITS-1:0]   pc_index;
  logic [TG_BITS-1:0]    pc_tag;
  logic [IDX_BITS-1:0]   fill_index;
  logic [TG_BITS-1:0]    fill_tag;

  icache_state_e         state;
  logic                  hit;
  logic                  miss_start;
  logic                  wr_en;
  logic [WSEL_BITS-1:0]  wr_word;
  logic                  fill_done;
  logic                  set_valid;

  assign pc_word    = WSEL_BITS'(addr_field(64'(pc_i), WSEL_LSB, WSEL_BITS));
  assign pc_index   = IDX_BITS'(addr_field(64'(pc_i), IDX_LSB, IDX_BITS));
  assign pc_tag     = TG_BITS'(addr_field(64'(pc_i), TG_LSB, TG_BITS));
  // The refill target is always taken from the latched request address so
  // a redirect of pc_i mid-refill cannot retarget the fill.
  assign fill_index = IDX_BITS'(addr_field(64'(mem_addr_o), IDX_LSB, IDX_BITS));
  assign fill_tag   = TG_BITS'(addr_field(64'(mem_addr_o), TG_LSB, TG_BITS));

  assign hit        = fetch_en_i & valid_q[pc_index] & (tag_q[pc_index] == pc_tag)
                    & (state == ST_IDLE);
  assign miss_start = fetch_en_i & ~hit & (state == ST_IDLE);
  assign stall_o    = (fetch_en_i & ~hit) | (state != ST_IDLE);
  assign instr_o    = hit ? data_q[pc_index][pc_word] : '0;

  icache_refill_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk           (clk),
    .rst           (rst),
    .start         (miss_start),
    .line_addr     (pc_i & LINE_MASK),
    .invalidate    (invalidate_i),
    .mem_req_ready (mem_req_ready_i),
    .mem_rvalid    (mem_rvalid_i),
    .state         (state),
    .mem_req_valid (mem_req_valid_o),
    .mem_addr      (mem_addr_o),
    .wr_en         (wr_en),
    .wr_word       (wr_word),
    .fill_done     (fill_done),
    .set_valid     (set_valid)
  );

  // Target line is invalidated when the refill starts so a partially
  // written line can never hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (invalidate_i) begin
      valid_q <= '0;
    end else begin
      if (miss_start) valid_q[pc_index]   <= 1'b0;
      if (set_valid)  valid_q[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)     data_q[fill_index][wr_word] <= mem_rdata_i;
    if (fill_done) tag_q[fill_index]           <= fill_tag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm (default geometry: 16 lines x 4 words).
// A transaction-level model of the cache contents and refill progress is
// checked against the DUT on every falling edge; directed sequences add
// literal expectations for addresses, data and stall lengths.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0;
  logic [31:0] instr_o;
  logic        stall_o;
  logic        invalidate = 1'b0;
  logic        mem_req_valid_o;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc),
    .fetch_en_i      (fetch_en),
    .instr_o         (instr_o),
    .stall_o         (stall_o),
    .invalidate_i    (invalidate),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready),
    .mem_addr_o      (mem_addr_o),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata)
  );

  // Backing memory, keyed by word address.
  logic [31:0] mem_img [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  localparam int NO_TXN = 0, AWAIT_ACCEPT = 1, RECEIVING = 2, COMMITTING = 3;
  bit   [15:0] m_valid = '0;
  logic [23:0] m_tag  [16];
  logic [31:0] m_line [16][4];
  int          m_txn = NO_TXN;
  int          m_beats = 0;
  logic [31:0] m_addr = '0;
  bit          m_drop = 1'b0;

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = '0; m_txn = NO_TXN; m_beats = 0; m_addr = '0; m_drop = 1'b0;
    end else begin
      if (m_txn == NO_TXN) begin
        m_drop = 1'b0;
        if (fetch_en && !model_hit(pc)) begin
          m_addr = {pc[31:4], 4'b0000};
          m_valid[pc[7:4]] = 1'b0;
          m_txn = AWAIT_ACCEPT;
        end
      end else if (m_txn == AWAIT_ACCEPT) begin
        if (invalidate) m_drop = 1'b1;
        if (mem_req_ready) begin m_txn = RECEIVING; m_beats = 0; end
      end else if (m_txn == RECEIVING) begin
        if (invalidate) m_drop = 1'b1;
        if (mem_rvalid) m_beats++;
        if (m_beats == 4) m_txn = COMMITTING;
      end else begin
        // The committed line must equal the backing memory contents.
        if (!m_drop && !invalidate) begin
          m_valid[m_addr[7:4]] = 1'b1;
          m_tag[m_addr[7:4]] = m_addr[31:8];
          for (int w = 0; w < 4; w++) m_line[m_addr[7:4]][w] = mem_img[int'(m_addr >> 2) + w];
        end
        m_txn = NO_TXN;
      end
      if (invalidate) m_valid = '0;
    end
  end

  // Compare process plus a stall-run length monitor.
  int stall_run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    bit          e_hit;
    bit          e_stall;
    logic [31:0] e_instr;
    e_hit   = fetch_en && (m_txn == NO_TXN) && model_hit(pc);
    e_stall = (fetch_en && !e_hit) || (m_txn != NO_TXN);
    e_instr = e_hit ? m_line[pc[7:4]][pc[3:2]] : 32'd0;
    check("cmp_stall", 32'(stall_o), 32'(e_stall));
    check("cmp_instr", instr_o, e_instr);
    check("cmp_req_valid", 32'(mem_req_valid_o), 32'(m_txn == AWAIT_ACCEPT));
    check("cmp_mem_addr", mem_addr_o, m_addr);
    if (stall_o) stall_run++;
    else begin
      if (stall_run > 0) last_run = stall_run;
      stall_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_line(input logic [31:0] base, input logic [31:0] first);
    for (int w = 0; w < 4; w++) mem_img[int'(base >> 2) + w] = first + 32'(w);
  endtask

  // Acts as the backing memory for one refill: waits for the request,
  // withholds ready for ready_delay cycles, then returns n_beats beats with
  // gap idle cycles between them. Optionally pulses invalidate or redirects
  // pc during a chosen beat. Returns at #1 after the edge of the last beat.
  task automatic serve(input int ready_delay, input int gap, input int n_beats,
                       input int inv_beat, input int redir_beat,
                       input logic [31:0] redir_pc, output logic [31:0] req_addr);
    int n = 0;
    while (mem_req_valid_o !== 1'b1 && n < 30) begin tick(); n++; end
    check("req_seen", 32'(mem_req_valid_o), 32'd1);
    req_addr = mem_addr_o;
    for (int i = 0; i < ready_delay; i++) begin
      check("req_hold_valid", 32'(mem_req_valid_o), 32'd1);
      check("req_hold_addr", mem_addr_o, req_addr);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int w = 0; w < n_beats; w++) begin
      if (w > 0) repeat (gap) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = mem_img[int'(req_addr >> 2) + w];
      invalidate = (w == inv_beat);
      if (w == redir_beat) pc = redir_pc;
      tick();
      mem_rvalid = 1'b0;
      invalidate = 1'b0;
    end
  endtask

  task automatic check_hit(input string name, input logic [31:0] exp);
    @(negedge clk); #1;
    check({name, "_stall"}, 32'(stall_o), 32'd0);
    check({name, "_instr"}, instr_o, exp);
    check({name, "_noreq"}, 32'(mem_req_valid_o), 32'd0);
  endtask

  task automatic check_miss(input string name);
    @(negedge clk); #1;
    check(name, 32'(stall_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    load_line(32'h000, 32'hA0);
    load_line(32'h100, 32'hB0);
    load_line(32'h030, 32'hC0);
    load_line(32'h010, 32'hD0);
    load_line(32'h050, 32'hE0);
    load_line(32'h020, 32'hF0);
    load_line(32'h040, 32'h1234_5670);
    load_line(32'h300, 32'h5A0);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("reset_mem_addr", mem_addr_o, 32'd0);
    check("reset_instr", instr_o, 32'd0);

    // 1. Cold miss at 0x00, immediate ready, back-to-back beats.
    pc = 32'h00; fetch_en = 1'b1;
    serve(0, 0, 4, -1, -1, 32'h0, a);
    check("t1_req_addr", a, 32'h00);
    tick();
    check_hit("t1_w0", 32'hA0);
    check("t1_stall_len", 32'(last_run), 32'd7);
    for (int w = 1; w < 4; w++) begin
      tick(); pc = 32'(w * 4);
      check_hit("t1_wn", 32'hA0 + 32'(w));
    end

    // 2. Conflict eviction at index 0, then the old line misses again.
    tick(); pc = 32'h100;
    serve(0, 0, 4, -1, -1, 32'h0, a);
    check("t2_req_addr", a, 32'h100);
    tick();
    check_hit("t2_hit", 32'hB0);
    tick(); pc = 32'h00;
    check_miss("t2_remiss");
    serve(0, 0, 4, -1, -1, 32'h0, a);
    tick();
    check_hit("t2_refill", 32'hA0);

    // 3. Ready withheld 3 cycles, one idle cycle between beats.
    tick(); pc = 32'h30;
    serve(3, 1, 4, -1, -1, 32'h0, a);
    check("t3_req_addr", a, 32'h30);
    tick();
    check_hit("t3_w0", 32'hC0);
    check("t3_stall_len", 32'(last_run), 32'd13);
    for (int w = 1; w < 4; w++) begin
      tick(); pc = 32'h30 + 32'(w * 4);
      check_hit("t3_wn", 32'hC0 + 32'(w));
    end

    // 4. Invalidate in IDLE, then invalidate during FILL.
    tick(); pc = 32'h10;
    serve(0, 0, 4, -1, -1, 32'h0, a);
    tick();
    check_hit("t4_line1", 32'hD0);
    tick(); fetch_en = 1'b0; invalidate = 1'b1;
    tick(); invalidate = 1'b0; fetch_en = 1'b1; pc = 32'h00;
    check_miss("t4_inv_miss0");
    serve(0, 0, 4, -1, -1, 32'h0, a);
    tick();
    check_hit("t4_refill0", 32'hA0);
    tick(); pc = 32'h10;
    check_miss("t4_inv_miss1");
    serve(0, 0, 4, -1, -1, 32'h0, a);
    tick();
    check_hit("t4_refill1", 32'hD0);
    tick(); pc = 32'h50;
    serve(0, 0, 4, 1, -1, 32'h0, a);
    tick();
    check_miss("t4_drop_miss");
    serve(0, 0, 4, -1, -1, 32'h0, a);
    check("t4_drop_req_addr", a, 32'h50);
    tick();
    check_hit("t4_drop_refill", 32'hE0);

    // 5. Redirect from 0x20 to 0x40 during FILL.
    tick(); pc = 32'h20;
    serve(0, 0, 4, -1, 1, 32'h40, a);
    check("t5_first_addr", a, 32'h20);
    tick();
    check_miss("t5_redir_miss");
    serve(0, 0, 4, -1, -1, 32'h0, a);
    check("t5_second_addr", a, 32'h40);
    tick();
    check_hit("t5_hit40", 32'h1234_5670);
    tick(); pc = 32'h20;
    check_hit("t5_hit20", 32'hF0);

    // 6. Asynchronous reset after two beats of a refill.
    tick(); pc = 32'h300;
    serve(0, 0, 2, -1, -1, 32'h0, a);
    check("t6_req_addr", a, 32'h300);
    rst = 1'b1; fetch_en = 1'b0;
    #1;
    check("t6_rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("t6_rst_stall", 32'(stall_o), 32'd0);
    check("t6_rst_mem_addr", mem_addr_o, 32'd0);
    check("t6_rst_instr", instr_o, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick(); pc = 32'h00; fetch_en = 1'b1;
    check_miss("t6_post_miss");
    serve(0, 0, 4, -1, -1, 32'h0, a);
    check("t6_post_addr", a, 32'h00);
    tick();
    check_hit("t6_post_hit", 32'hA0);
    check("t6_stall_len", 32'(last_run), 32'd7);

    tick(); fetch_en = 1'b0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
